// File: rtl/adc_sample_cond.sv
// adc_sample_cond: per-channel ADC word conditioner -- format conversion, IIR DC removal,
// saturation and out-of-range statistics with a fixed two-cycle latency.
module adc_sample_cond #(
    parameter int CH_NUM   = 2,
    parameter int D_BIT    = 10,
    parameter int DC_SHIFT = 10,
    parameter int SETTLE_N = 4096,
    parameter int CNT_W    = 16
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic                      iEN,
    input  logic                      iDFS,
    input  logic                      iVALID,
    input  logic [CH_NUM*D_BIT-1:0]   iDATA,
    input  logic [CH_NUM-1:0]         iOTR,
    input  logic                      iCLR_OTR,
    output logic [CH_NUM*D_BIT-1:0]   oDATA,
    output logic                      oVALID,
    output logic                      oSETTLED,
    output logic [CH_NUM-1:0]         oOTR_STICKY,
    output logic [CH_NUM*CNT_W-1:0]   oOTR_CNT
);
    localparam int AW = D_BIT + DC_SHIFT + 1;
    localparam int SW = $clog2(SETTLE_N + 1);
    localparam logic signed [D_BIT+1:0] HI = (D_BIT+2)'(2**(D_BIT-1) - 1);
    localparam logic signed [D_BIT+1:0] LO = -HI - 1;
    localparam logic [D_BIT-1:0] YMAX = {1'b0, {(D_BIT-1){1'b1}}};
    localparam logic [D_BIT-1:0] YMIN = {1'b1, {(D_BIT-1){1'b0}}};

    logic          v1;
    logic [SW-1:0] settleCnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N || !iEN) begin
            v1        <= 1'b0;
            oVALID    <= 1'b0;
            settleCnt <= '0;
            oSETTLED  <= 1'b0;
        end else begin
            v1       <= iVALID;
            oVALID   <= v1;
            oSETTLED <= settleCnt == SW'(SETTLE_N);
            if (v1 && settleCnt != SW'(SETTLE_N))
                settleCnt <= settleCnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : gCh
        logic        [D_BIT-1:0] raw;
        logic        [D_BIT-1:0] s1;
        logic                    otr1;
        logic signed [AW-1:0]    acc;
        logic signed [D_BIT:0]   dc;
        logic signed [D_BIT+1:0] diff;
        logic        [D_BIT-1:0] y;
        logic        [D_BIT-1:0] dOut;
        logic        [CNT_W-1:0] cnt;
        logic                    sticky;
        logic                    evt;

        assign raw  = iDATA[g*D_BIT +: D_BIT];
        // floor(acc / 2^DC_SHIFT) is simply the upper slice of the signed accumulator
        assign dc   = acc[AW-1:DC_SHIFT];
        assign diff = {{2{s1[D_BIT-1]}}, s1} - {dc[D_BIT], dc};
        assign evt  = iEN && v1 && otr1;

        always_comb begin
            y = otr1 ? (s1[D_BIT-1] ? YMIN : YMAX) :
                (diff > HI) ? YMAX : (diff < LO) ? YMIN : diff[D_BIT-1:0];
        end

        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                s1   <= '0;
                otr1 <= 1'b0;
                acc  <= '0;
                dOut <= '0;
            end else begin
                if (iEN && iVALID) begin
                    s1   <= iDFS ? raw : {~raw[D_BIT-1], raw[D_BIT-2:0]};
                    otr1 <= iOTR[g];
                end
                if (!iEN)
                    acc <= '0;
                else if (v1) begin
                    acc  <= acc + {{(AW-D_BIT){s1[D_BIT-1]}}, s1} - {{(AW-D_BIT-1){dc[D_BIT]}}, dc};
                    dOut <= y;
                end
            end
        end

        // a clear coinciding with an event leaves exactly that event recorded
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (iCLR_OTR) begin
                cnt    <= CNT_W'(evt);
                sticky <= evt;
            end else if (evt) begin
                sticky <= 1'b1;
                if (~&cnt)
                    cnt <= cnt + 1'b1;
            end
        end

        assign oDATA[g*D_BIT +: D_BIT]    = dOut;
        assign oOTR_CNT[g*CNT_W +: CNT_W] = cnt;
        assign oOTR_STICKY[g]             = sticky;
    end
endmodule

// File: tb/tb_adc_sample_cond.sv
// tb_adc_sample_cond: randomized and directed checks of adc_sample_cond against an
// arithmetic reference model (DC_SHIFT=4, SETTLE_N=16, CNT_W=8).
module tb_adc_sample_cond;
    localparam int CH = 2, DB = 10, DS = 4, SN = 16, CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic iCLK = 0, iRST_N = 0, iEN = 0, iDFS = 0, iVALID = 0, iCLR_OTR = 0;
    logic [CH*DB-1:0] iDATA = '0;
    logic [CH-1:0]    iOTR = '0;
    logic [CH*DB-1:0] oDATA;
    logic             oVALID, oSETTLED;
    logic [CH-1:0]    oOTR_STICKY;
    logic [CH*CW-1:0] oOTR_CNT;

    adc_sample_cond #(.CH_NUM(CH), .D_BIT(DB), .DC_SHIFT(DS), .SETTLE_N(SN), .CNT_W(CW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iDFS(iDFS), .iVALID(iVALID),
        .iDATA(iDATA), .iOTR(iOTR), .iCLR_OTR(iCLR_OTR), .oDATA(oDATA), .oVALID(oVALID),
        .oSETTLED(oSETTLED), .oOTR_STICKY(oOTR_STICKY), .oOTR_CNT(oOTR_CNT)
    );

    always #5 iCLK = ~iCLK;

    int nAssert = 0, nFail = 0;

    logic       en, dfs, vld, clr;
    logic [9:0] din [CH];
    logic       otr [CH];

    int     mV1, mOv, mSc, mSet;
    int     mS1 [CH], mOtr1 [CH], mOd [CH], mOc [CH], mSt [CH];
    longint mAcc [CH];

    function automatic int conv(logic [9:0] r, logic f);
        int u = int'(r);
        return f ? (u >= 512 ? u - 1024 : u) : u - 512;
    endfunction

    function automatic longint floorDiv(longint a, longint d);
        return a >= 0 ? a / d : -((-a + d - 1) / d);
    endfunction

    task automatic modelReset();
        mV1 = 0; mOv = 0; mSc = 0; mSet = 0;
        for (int c = 0; c < CH; c++) begin
            mS1[c] = 0; mOtr1[c] = 0; mOd[c] = 0; mOc[c] = 0; mSt[c] = 0; mAcc[c] = 0;
        end
    endtask

    task automatic modelEdge();
        for (int c = 0; c < CH; c++) begin
            int ev = (en && mV1 && mOtr1[c]) ? 1 : 0;
            if (clr) begin mOc[c] = ev; mSt[c] = ev; end
            else if (ev != 0) begin mSt[c] = 1; if (mOc[c] < CMAX) mOc[c]++; end
        end
        if (!en) begin
            mV1 = 0; mOv = 0; mSc = 0; mSet = 0;
            for (int c = 0; c < CH; c++) mAcc[c] = 0;
        end else begin
            mSet = (mSc == SN) ? 1 : 0;
            mOv = mV1;
            if (mV1 != 0) begin
                for (int c = 0; c < CH; c++) begin
                    longint dc = floorDiv(mAcc[c], 1 << DS);
                    longint y = mS1[c] - dc;
                    y = y > 511 ? 511 : y < -512 ? -512 : y;
                    if (mOtr1[c] != 0) y = mS1[c] >= 0 ? 511 : -512;
                    mOd[c] = int'(y);
                    mAcc[c] += mS1[c] - dc;
                end
                if (mSc < SN) mSc++;
            end
            if (vld) for (int c = 0; c < CH; c++) begin mS1[c] = conv(din[c], dfs); mOtr1[c] = otr[c]; end
            mV1 = vld;
        end
    endtask

    task automatic chk(string tag, logic signed [31:0] obs, int exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("valid", oVALID, mOv);
        chk("settled", oSETTLED, mSet);
        for (int c = 0; c < CH; c++) begin
            chk("data", $signed(oDATA[c*DB +: DB]), mOd[c]);
            chk("otr_cnt", oOTR_CNT[c*CW +: CW], mOc[c]);
            chk("otr_sticky", oOTR_STICKY[c], mSt[c]);
        end
    endtask

    task automatic step();
        iEN = en; iDFS = dfs; iVALID = vld; iCLR_OTR = clr;
        iDATA = {din[1], din[0]};
        iOTR = {otr[1], otr[0]};
        modelEdge();
        @(posedge iCLK);
        #1;
        checkAll();
    endtask

    task automatic setBoth(logic [9:0] a, logic [9:0] b);
        din[0] = a; din[1] = b;
    endtask

    task automatic checkZero(string tag);
        chk({tag, "_valid"}, oVALID, 0);
        chk({tag, "_settled"}, oSETTLED, 0);
        chk({tag, "_data"}, oDATA, 0);
        chk({tag, "_cnt"}, oOTR_CNT, 0);
        chk({tag, "_sticky"}, oOTR_STICKY, 0);
    endtask

    initial begin
        en = 0; dfs = 0; vld = 0; clr = 0; otr[0] = 0; otr[1] = 0; setBoth(0, 0);
        modelReset();
        #3 checkZero("reset");
        @(negedge iCLK) iRST_N = 1;
        en = 1;

        // straight binary: midscale, full scale, zero
        vld = 1; setBoth(10'h200, 10'h200); step(); chk("lat_v0", oVALID, 0);
        setBoth(10'h3FF, 10'h3FF); step(); chk("lat_v1", oVALID, 1); chk("fmt_mid", $signed(oDATA[9:0]), 0);
        setBoth(10'h000, 10'h000); step(); chk("fmt_max", $signed(oDATA[9:0]), 511);
        vld = 0; step(); chk("fmt_min", $signed(oDATA[9:0]), -512);

        // OTR on channel 0 only
        dfs = 1; clr = 1; step(); clr = 0;
        vld = 1; otr[0] = 1; setBoth(300, 5); step();
        vld = 0; otr[0] = 0; step();
        chk("otr_force", $signed(oDATA[9:0]), 511);
        chk("otr_cnt1", oOTR_CNT[7:0], 1);
        chk("otr_sticky1", oOTR_STICKY[0], 1);
        chk("otr_ch1_cnt", oOTR_CNT[15:8], 0);
        chk("otr_ch1_sticky", oOTR_STICKY[1], 0);
        vld = 1; otr[0] = 1; step(); vld = 0; otr[0] = 0; step();
        chk("otr_cnt2", oOTR_CNT[7:0], 2);
        vld = 1; otr[0] = 1; step(); vld = 0; otr[0] = 0; clr = 1; step(); clr = 0;
        chk("otr_clr_evt", oOTR_CNT[7:0], 1);
        vld = 1; otr[0] = 1;
        for (int i = 0; i < CMAX + 6; i++) step();
        vld = 0; otr[0] = 0; step(); step();
        chk("otr_sat", oOTR_CNT[7:0], CMAX);

        // disable mid-stream, then re-enable and watch the settle flag
        vld = 1; setBoth(40, 60);
        for (int i = 0; i < 20; i++) step();
        chk("pre_dis_settled", oSETTLED, 1);
        en = 0; step();
        chk("dis_valid", oVALID, 0);
        chk("dis_settled", oSETTLED, 0);
        chk("dis_cnt", oOTR_CNT[7:0], CMAX);
        en = 1; setBoth(123, 10'h3F0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 2) begin
                chk("reen_raw0", $signed(oDATA[9:0]), 123);
                chk("reen_raw1", $signed(oDATA[19:10]), -16);
            end
            if (i == 17) chk("settle_early", oSETTLED, 0);
            if (i == 18) chk("settle_rise", oSETTLED, 1);
        end

        // DC convergence on +100 / -100
        en = 0; vld = 0; step(); en = 1; vld = 1;
        setBoth(100, 10'(1024 - 100));
        for (int i = 0; i < 300; i++) step();
        chk("dc_conv0", $signed(oDATA[9:0]), 0);
        chk("dc_conv1", $signed(oDATA[19:10]), 0);
        chk("dc_acc0", int'(mAcc[0] >= 1600 && mAcc[0] <= 1615), 1);

        // saturation after converging at the opposite rail
        en = 0; step(); en = 1;
        setBoth(10'(1024 - 500), 500);
        for (int i = 0; i < 300; i++) step();
        setBoth(511, 10'h200); step(); vld = 0; step();
        chk("sat_pos", $signed(oDATA[9:0]), 511);
        chk("sat_neg", $signed(oDATA[19:10]), -512);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 19) != 0;
            dfs = $urandom_range(0, 1) != 0;
            vld = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 29) == 0;
            for (int c = 0; c < CH; c++) begin
                din[c] = 10'($urandom);
                otr[c] = $urandom_range(0, 9) == 0;
            end
            step();
        end

        // asynchronous reset between edges while streaming
        en = 1; vld = 1; clr = 0; otr[0] = 1; otr[1] = 0; setBoth(200, 300);
        step(); step(); step();
        otr[0] = 0;
        #2 iRST_N = 0;
        #1 modelReset();
        checkZero("async_rst");
        @(negedge iCLK) iRST_N = 1;
        dfs = 1; setBoth(77, 10'h3FF); step();
        chk("post_rst_v0", oVALID, 0);
        vld = 0; step();
        chk("post_rst_v1", oVALID, 1);
        chk("post_rst_data0", $signed(oDATA[9:0]), 77);
        chk("post_rst_data1", $signed(oDATA[19:10]), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
